// File: rtl/pll_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pll_cfg_pkg
//  Purpose  : Shared definitions for the PLL reconfiguration sequencer:
//             FSM state encoding, error codes, default scan-chain length and
//             bit offsets of the counter fields inside the scan image.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pll_cfg_pkg;

  // Cyclone IV E PLL scan chain length
  localparam int SCAN_LEN_DEF = 144;

  // Sequencer states, explicitly encoded
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD      = 4'd1,
    ST_SHIFT     = 4'd2,
    ST_UPDATE    = 4'd3,
    ST_WAIT_DONE = 4'd4,
    ST_ARESET    = 4'd5,
    ST_WAIT_LOCK = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERR       = 4'd8
  } state_e;

  // err_code values
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_SCANDONE = 2'b01;
  localparam logic [1:0] ERR_LOCK     = 2'b10;

  // Each post-scale / feedback counter occupies an 18-bit field:
  // {high count[7:0], low count[7:0], bypass, odd-division}.
  // Offsets are LSB indices within the image; the charge-pump / loop-filter
  // settings fill the top 18 bits and are shifted out first.
  localparam int CNT_FIELD_W = 18;
  localparam int OFS_C4      = 0;
  localparam int OFS_C3      = 18;
  localparam int OFS_C2      = 36;
  localparam int OFS_C1      = 54;
  localparam int OFS_C0      = 72;
  localparam int OFS_N       = 90;
  localparam int OFS_M       = 108;
  localparam int OFS_CP_LF   = 126;

  // Assemble one counter field for placement into a scan image
  function automatic logic [CNT_FIELD_W-1:0] pack_counter(
    input logic [7:0] hi,
    input logic [7:0] lo,
    input logic       bypass,
    input logic       odd
  );
    return {hi, lo, bypass, odd};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reconfig_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pll_reconfig_ctrl_if
//  Purpose  : Host-side request/status bundle between the JTAG register file
//             (master) and the PLL reconfiguration sequencer (slave).
//  Signals  : req       - start request (master -> slave)
//             cfg_bits  - scan image, MSB shifted first (master -> slave)
//             busy      - operation in progress (slave -> master)
//             done/err  - 1-cycle completion / timeout pulses
//             err_code  - 00 none, 01 scandone timeout, 10 lock timeout
//  Revision : 1.0  initial release
// ============================================================================
interface pll_reconfig_ctrl_if
  import pll_cfg_pkg::*;
#(
  parameter int SCAN_LEN = SCAN_LEN_DEF
) ();

  logic                req;
  logic [SCAN_LEN-1:0] cfg_bits;
  logic                busy;
  logic                done;
  logic                err;
  logic [1:0]          err_code;

  modport master (
    output req,
    output cfg_bits,
    input  busy,
    input  done,
    input  err,
    input  err_code
  );

  modport slave (
    input  req,
    input  cfg_bits,
    output busy,
    output done,
    output err,
    output err_code
  );

endinterface
`default_nettype wire

// File: rtl/pll_scanclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pll_scanclk_gen
//  Purpose  : Divides clk down to the PLL scan clock. scanclk toggles every
//             DIV clk cycles while enabled and is held low (divider cleared)
//             when disabled, so every enable starts with a full low half.
//  Ports    : clk, rst   - system clock, synchronous active-high reset
//             i_en       - run the divider
//             o_scanclk  - registered scan clock
//             o_rise     - high in the cycle whose closing edge raises scanclk
//             o_fall     - high in the cycle whose closing edge lowers scanclk
//  Revision : 1.0  initial release
// ============================================================================
module pll_scanclk_gen #(
  parameter int DIV = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_en,
  output logic      o_scanclk,
  output logic      o_rise,
  output logic      o_fall
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_scanclk;
  logic             w_tick;

  // Strobes lead the scanclk edge by one clk, letting the consumer update
  // its own registers on the same clk edge that moves scanclk.
  assign w_tick = i_en && (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt     <= '0;
      r_scanclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt     <= '0;
      r_scanclk <= ~r_scanclk;
    end else begin
      r_cnt     <= r_cnt + CNT_W'(1);
    end
  end

  assign o_scanclk = r_scanclk;
  assign o_rise    = w_tick & ~r_scanclk;
  assign o_fall    = w_tick &  r_scanclk;

endmodule
`default_nettype wire

// File: rtl/pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pll_reconfig_ctrl
//  Purpose  : Dynamic reconfiguration sequencer for the Cyclone IV E main PLL.
//             Shifts a scan image into the PLL scan chain, pulses
//             configupdate, waits for scandone, resets the PLL and waits for
//             lock. Timeouts on either wait end the operation with an error.
//  Ports    : clk, rst            - 50 MHz free-running clock, sync reset
//             if_host (slave)     - req / cfg_bits / busy / done / err / err_code
//             o_pll_scanclk       - altpll scanclk
//             o_pll_scanclkena    - altpll scanclkena
//             o_pll_scandata      - altpll scandata
//             o_pll_configupdate  - altpll configupdate
//             o_pll_areset        - altpll areset
//             i_pll_scandone      - altpll scandone
//             i_pll_locked        - altpll locked (asynchronous)
//  Options  : PLL_RECONFIG_READBACK_EN adds i_pll_scandataout and o_rb_bits,
//             capturing the previous chain contents while shifting.
//  Revision : 1.0  initial release
// ============================================================================
module pll_reconfig_ctrl
  import pll_cfg_pkg::*;
#(
  parameter int SCAN_LEN    = SCAN_LEN_DEF,
  parameter int SCANCLK_DIV = 4,
  parameter int TIMEOUT_CYC = 65535,
  parameter int ARESET_CYC  = 16
) (
  input  wire logic               clk,
  input  wire logic               rst,
  pll_reconfig_ctrl_if.slave      if_host,
  output logic                    o_pll_scanclk,
  output logic                    o_pll_scanclkena,
  output logic                    o_pll_scandata,
  output logic                    o_pll_configupdate,
  output logic                    o_pll_areset,
  input  wire logic               i_pll_scandone,
  input  wire logic               i_pll_locked
`ifdef PLL_RECONFIG_READBACK_EN
  ,
  input  wire logic               i_pll_scandataout,
  output logic [SCAN_LEN-1:0]     o_rb_bits
`endif
);

  localparam int BITCNT_W = $clog2(SCAN_LEN);
  localparam int TMR_MAX  = (TIMEOUT_CYC > ARESET_CYC) ? TIMEOUT_CYC : ARESET_CYC;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  localparam logic [BITCNT_W-1:0] c_LAST_BIT = BITCNT_W'(SCAN_LEN - 1);
  localparam logic [TMR_W-1:0]    c_TMO      = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]    c_ARESET   = TMR_W'(ARESET_CYC - 1);

  state_e               r_state;
  logic [SCAN_LEN-1:0]  r_shreg;
  logic [BITCNT_W-1:0]  r_bitcnt;
  logic                 r_last;
  logic [TMR_W-1:0]     r_timer;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [1:0]           r_err_code;
  logic                 r_scanclkena;
  logic                 r_scandata;
  logic                 r_configupdate;
  logic                 r_areset;
  logic                 r_lock_s1;
  logic                 r_lock_s2;

  logic                 w_sclk_en;
  logic                 w_rise;
  logic                 w_fall;

  // scanclk runs through shifting, the configupdate period and the scandone
  // wait; it is parked low everywhere else.
  assign w_sclk_en = (r_state == ST_SHIFT) || (r_state == ST_UPDATE) ||
                     (r_state == ST_WAIT_DONE);

  pll_scanclk_gen #(
    .DIV (SCANCLK_DIV)
  ) u_sclk (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_sclk_en),
    .o_scanclk (o_pll_scanclk),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  // locked comes straight from the PLL, asynchronous to clk
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= i_pll_locked;
      r_lock_s2 <= r_lock_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_shreg        <= '0;
      r_bitcnt       <= '0;
      r_last         <= 1'b0;
      r_timer        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_err_code     <= ERR_NONE;
      r_scanclkena   <= 1'b0;
      r_scandata     <= 1'b0;
      r_configupdate <= 1'b0;
      r_areset       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (if_host.req) begin
            r_shreg    <= if_host.cfg_bits;
            r_busy     <= 1'b1;
            r_err_code <= ERR_NONE;
            r_state    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          r_scanclkena <= 1'b1;
          r_scandata   <= r_shreg[SCAN_LEN-1];
          r_bitcnt     <= '0;
          r_last       <= 1'b0;
          r_state      <= ST_SHIFT;
        end

        // Bits advance on scanclk falling edges only, so scandata is stable
        // around every rising edge. r_last marks that the final rising edge
        // has been issued; the following falling edge closes the shift.
        ST_SHIFT: begin
          if (w_rise) begin
            r_last <= (r_bitcnt == c_LAST_BIT);
            if (r_bitcnt != c_LAST_BIT) begin
              r_bitcnt <= r_bitcnt + BITCNT_W'(1);
            end
          end else if (w_fall) begin
            if (r_last) begin
              r_scanclkena   <= 1'b0;
              r_scandata     <= 1'b0;
              r_configupdate <= 1'b1;
              r_state        <= ST_UPDATE;
            end else begin
              r_shreg    <= {r_shreg[SCAN_LEN-2:0], 1'b0};
              r_scandata <= r_shreg[SCAN_LEN-2];
            end
          end
        end

        // configupdate rises on a falling scanclk edge and drops on the next
        // one: one full scanclk period containing exactly one rising edge.
        ST_UPDATE: begin
          if (w_fall) begin
            r_configupdate <= 1'b0;
            r_timer        <= '0;
            r_state        <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (i_pll_scandone) begin
            r_areset <= 1'b1;
            r_timer  <= '0;
            r_state  <= ST_ARESET;
          end else if (r_timer == c_TMO) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_SCANDONE;
            r_timer    <= '0;
            r_state    <= ST_ERR;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        ST_ARESET: begin
          if (r_timer == c_ARESET) begin
            r_areset <= 1'b0;
            r_timer  <= '0;
            r_state  <= ST_WAIT_LOCK;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (r_lock_s2) begin
            r_done  <= 1'b1;
            r_timer <= '0;
            r_state <= ST_DONE;
          end else if (r_timer == c_TMO) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_LOCK;
            r_timer    <= '0;
            r_state    <= ST_ERR;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        ST_ERR: begin
          r_err    <= 1'b0;
          r_busy   <= 1'b0;
          r_areset <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PLL_RECONFIG_READBACK_EN
  // The old chain content emerges on scandataout as the new image goes in;
  // sampling on each shift rising edge rebuilds it MSB first.
  logic [SCAN_LEN-1:0] r_rb_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rb_bits <= '0;
    end else if ((r_state == ST_SHIFT) && w_rise) begin
      r_rb_bits <= {r_rb_bits[SCAN_LEN-2:0], i_pll_scandataout};
    end
  end

  assign o_rb_bits = r_rb_bits;
`endif

  assign if_host.busy     = r_busy;
  assign if_host.done     = r_done;
  assign if_host.err      = r_err;
  assign if_host.err_code = r_err_code;

  assign o_pll_scanclkena   = r_scanclkena;
  assign o_pll_scandata     = r_scandata;
  assign o_pll_configupdate = r_configupdate;
  assign o_pll_areset       = r_areset;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_reconfig_ctrl
//  Purpose  : Self-checking bench for pll_reconfig_ctrl with a behavioural
//             altpll scan-chain model (scandone 10 cycles after configupdate,
//             locked 50 cycles after areset release).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pll_reconfig_ctrl;
  import pll_cfg_pkg::*;

  localparam int LEN = 144;
  localparam int DIV = 4;
  localparam int TMO = 300;
  localparam int ARC = 16;

  logic clk;
  logic rst;
  logic o_pll_scanclk, o_pll_scanclkena, o_pll_scandata;
  logic o_pll_configupdate, o_pll_areset;
  logic pll_scandone, pll_locked;
`ifdef PLL_RECONFIG_READBACK_EN
  logic           pll_scandataout;
  logic [LEN-1:0] rb_bits;
  logic [LEN-1:0] rb_preload;
  logic [LEN-1:0] rb_at_done;
  int             rb_idx;
`endif

  pll_reconfig_ctrl_if #(.SCAN_LEN(LEN)) hif ();

  pll_reconfig_ctrl #(
    .SCAN_LEN    (LEN),
    .SCANCLK_DIV (DIV),
    .TIMEOUT_CYC (TMO),
    .ARESET_CYC  (ARC)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .if_host            (hif),
    .o_pll_scanclk      (o_pll_scanclk),
    .o_pll_scanclkena   (o_pll_scanclkena),
    .o_pll_scandata     (o_pll_scandata),
    .o_pll_configupdate (o_pll_configupdate),
    .o_pll_areset       (o_pll_areset),
    .i_pll_scandone     (pll_scandone),
    .i_pll_locked       (pll_locked)
`ifdef PLL_RECONFIG_READBACK_EN
    ,
    .i_pll_scandataout  (pll_scandataout),
    .o_rb_bits          (rb_bits)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor + PLL model state ----------------
  int mode;          // 0 normal, 1 never scandone, 2 never lock
  bit q_bits[$];     // scandata observed at each shift rising scanclk edge
  int cyc, cu_cnt, cu_rises, ar_cnt, done_cnt, err_cnt, stab_viol;
  int cu_fall_cyc, ar_fall_cyc, err_cyc;
  int sd_tmr, lk_tmr;
  logic prev_sclk, prev_data, prev_cu, prev_ar;

  initial begin
    cyc = 0; sd_tmr = 0; lk_tmr = 0;
    prev_sclk = 1'b0; prev_data = 1'b0; prev_cu = 1'b0; prev_ar = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_pll_scanclk && !prev_sclk) begin
        if (o_pll_scanclkena) begin
          q_bits.push_back(o_pll_scandata);
          if (o_pll_scandata !== prev_data) stab_viol++;
`ifdef PLL_RECONFIG_READBACK_EN
          rb_idx++;
          pll_scandataout = (rb_idx < LEN) ? rb_preload[LEN-1-rb_idx] : 1'b0;
`endif
        end
        if (o_pll_configupdate) cu_rises++;
      end
      if (o_pll_configupdate) cu_cnt++;
      if (o_pll_areset) ar_cnt++;
      if (!o_pll_configupdate && prev_cu) cu_fall_cyc = cyc;
      if (!o_pll_areset && prev_ar) ar_fall_cyc = cyc;
      if (hif.done) begin
        done_cnt++;
`ifdef PLL_RECONFIG_READBACK_EN
        rb_at_done = rb_bits;
`endif
      end
      if (hif.err) begin
        if (err_cnt == 0) err_cyc = cyc;
        err_cnt++;
      end
      // behavioural altpll
      if (o_pll_configupdate && !prev_cu) sd_tmr = 10;
      else if (sd_tmr > 0) begin
        sd_tmr--;
        if (sd_tmr == 0 && mode != 1) pll_scandone = 1'b1;
      end
      if (o_pll_areset) begin
        pll_scandone = 1'b0;
        pll_locked   = 1'b0;
        lk_tmr       = 0;
      end else if (prev_ar) lk_tmr = 50;
      else if (lk_tmr > 0) begin
        lk_tmr--;
        if (lk_tmr == 0 && mode != 2) pll_locked = 1'b1;
      end
      prev_sclk = o_pll_scanclk;
      prev_data = o_pll_scandata;
      prev_cu   = o_pll_configupdate;
      prev_ar   = o_pll_areset;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [LEN-1:0] observed_image();
    logic [LEN-1:0] v = '0;
    foreach (q_bits[i]) v = {v[LEN-2:0], q_bits[i]};
    return v;
  endfunction

  function automatic logic [9:0] all_outs();
    return {hif.busy, hif.done, hif.err, hif.err_code, o_pll_scanclk,
            o_pll_scanclkena, o_pll_scandata, o_pll_configupdate, o_pll_areset};
  endfunction

  function automatic logic [LEN-1:0] rand_image();
    logic [LEN-1:0] v;
    for (int j = 0; j < LEN; j++) v[j] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic start_op(input logic [LEN-1:0] cfg, input int md);
    mode = md;
    q_bits.delete();
    cu_cnt = 0; cu_rises = 0; ar_cnt = 0; done_cnt = 0; err_cnt = 0; stab_viol = 0;
    cu_fall_cyc = -1000; ar_fall_cyc = -1000; err_cyc = 0;
    pll_scandone = 1'b0;
`ifdef PLL_RECONFIG_READBACK_EN
    rb_idx = 0;
    pll_scandataout = rb_preload[LEN-1];
`endif
    @(negedge clk);
    hif.req      = 1'b1;
    hif.cfg_bits = cfg;
    @(negedge clk);
    hif.req      = 1'b0;
    hif.cfg_bits = ~cfg;  // image must have been captured already
    chk("busy_on_accept", hif.busy, 1);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!((done_cnt + err_cnt) > 0 && !hif.busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("op_completes", n < 20000, 1);
  endtask

  task automatic wait_bits(input int nb);
    int n = 0;
    while (q_bits.size() < nb && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit", n < 20000, 1);
  endtask

  task automatic check_ok(input logic [LEN-1:0] cfg, input string t);
    chk({t, "_nbits"},    q_bits.size(), LEN);
    chk({t, "_image"},    observed_image(), cfg);
    chk({t, "_done"},     done_cnt, 1);
    chk({t, "_err"},      err_cnt, 0);
    chk({t, "_errcode"},  hif.err_code, ERR_NONE);
    chk({t, "_cu_width"}, cu_cnt, 2 * DIV);
    chk({t, "_cu_rises"}, cu_rises, 1);
    chk({t, "_areset"},   ar_cnt, ARC);
    chk({t, "_stable"},   stab_viol, 0);
    chk({t, "_idle"},     all_outs(), 10'd0);
`ifdef PLL_RECONFIG_READBACK_EN
    chk({t, "_readback"}, rb_at_done, rb_preload);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [LEN-1:0] cfg_a, cfg_b;
    rst = 1'b1;
    hif.req = 1'b0;
    hif.cfg_bits = '0;
    pll_scandone = 1'b0;
    pll_locked = 1'b1;
    mode = 0;
`ifdef PLL_RECONFIG_READBACK_EN
    rb_preload = {9{16'hDEAD}};
    pll_scandataout = 1'b0;
    rb_idx = 0;
`endif
    repeat (5) @(negedge clk);
    chk("reset_outputs", all_outs(), 10'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // normal reconfigurations
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        for (int j = 0; j < LEN; j++) cfg_a[j] = 1'(j % 2);  // 1010... MSB first
      end else if (i == 1) begin
        cfg_a = '0;
        cfg_a[OFS_M  +: CNT_FIELD_W] = pack_counter(8'd6, 8'd6, 1'b0, 1'b0);
        cfg_a[OFS_N  +: CNT_FIELD_W] = pack_counter(8'd1, 8'd1, 1'b1, 1'b0);
        cfg_a[OFS_C0 +: CNT_FIELD_W] = pack_counter(8'd3, 8'd2, 1'b0, 1'b1);
        cfg_a[OFS_CP_LF +: CNT_FIELD_W] = 18'h2A5C3;
      end else begin
        cfg_a = rand_image();
      end
      start_op(cfg_a, 0);
      wait_end();
      check_ok(cfg_a, "normal");
      repeat (4) @(negedge clk);
    end

    // scandone never arrives
    cfg_a = rand_image();
    start_op(cfg_a, 1);
    wait_end();
    chk("sd_to_err",     err_cnt, 1);
    chk("sd_to_done",    done_cnt, 0);
    chk("sd_to_code",    hif.err_code, ERR_SCANDONE);
    chk("sd_to_areset",  ar_cnt, 0);
    chk("sd_to_latency", err_cyc - cu_fall_cyc, TMO + 1);
    repeat (5) @(negedge clk);
    chk("sd_to_code_held", hif.err_code, ERR_SCANDONE);

    // lock never arrives
    cfg_a = rand_image();
    start_op(cfg_a, 2);
    wait_end();
    chk("lk_to_err",     err_cnt, 1);
    chk("lk_to_done",    done_cnt, 0);
    chk("lk_to_code",    hif.err_code, ERR_LOCK);
    chk("lk_to_areset",  ar_cnt, ARC);
    chk("lk_to_latency", err_cyc - ar_fall_cyc, TMO + 1);
    repeat (4) @(negedge clk);

    // second request during shifting is ignored
    cfg_a = rand_image();
    cfg_b = ~cfg_a;
    start_op(cfg_a, 0);
    wait_bits(30);
    hif.req = 1'b1;
    hif.cfg_bits = cfg_b;
    @(negedge clk);
    hif.req = 1'b0;
    chk("midreq_busy", hif.busy, 1);
    wait_end();
    check_ok(cfg_a, "midreq");
    repeat (4) @(negedge clk);

    // reset in the middle of shifting, then restart
    cfg_a = rand_image();
    start_op(cfg_a, 0);
    wait_bits(70);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", all_outs(), 10'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cfg_b = rand_image();
    start_op(cfg_b, 0);
    wait_end();
    check_ok(cfg_b, "restart");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
